// File: rtl/dc_req_queue.sv
// In-order request queue feeding the DRAM-cache tag-compare stage: accept, issue DRAM reads, hold until response.
// Optional performance counters are built only when DC_REQ_Q_PERF_EN is defined.
module dc_req_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 81,
    parameter int IDX_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [DATA_W-1:0]          req_data_i,
    output logic [IDX_W-1:0]           araddr_o,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    output logic [DATA_W-1:0]          fifo_data_o,
    output logic                       fifo_valid_o,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o,
    output logic [31:0]                perf_req_o,
    output logic [31:0]                perf_stall_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, iss_ptr, rd_ptr;
    logic              push, issue, pop;

    // All handshakes qualify against register-decoded status only.
    assign count_o      = wr_ptr - rd_ptr;
    assign req_ready_o  = (count_o != PW'(DEPTH));
    assign arvalid_o    = (iss_ptr != wr_ptr);
    assign fifo_valid_o = (rd_ptr != iss_ptr);

    assign push  = req_valid_i & req_ready_o;
    assign issue = arvalid_o & arready_i;
    assign pop   = pop_i & fifo_valid_o;

    // Storage is never reset; outputs are masked while their region is empty.
    assign araddr_o    = arvalid_o ? mem[iss_ptr[AW-1:0]][8 +: IDX_W] : '0;
    assign fifo_data_o = fifo_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= req_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            rd_ptr  <= '0;
            err_o   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                iss_ptr <= iss_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A response handshake with nothing issued means the pairing is lost.
            if (pop_i && !fifo_valid_o) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef DC_REQ_Q_PERF_EN
    logic [31:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) begin
                perf_req_q <= perf_req_q + 32'd1;
            end
            if (req_valid_i && !req_ready_o) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_req_o   = perf_req_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_req_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dc_req_queue.sv
// Self-checking bench for dc_req_queue: directed scenarios plus random traffic against a queue-based model.
module tb_dc_req_queue;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 81;
    localparam int IDX_W  = 8;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [DATA_W-1:0] req_data_i = '0;
    logic [IDX_W-1:0]  araddr_o;
    logic              arvalid_o;
    logic              arready_i = 1'b0;
    logic [DATA_W-1:0] fifo_data_o;
    logic              fifo_valid_o;
    logic              pop_i = 1'b0;
    logic [PW-1:0]     count_o;
    logic              err_o;
    logic [31:0]       perf_req_o;
    logic [31:0]       perf_stall_o;

    int compared   = 0;
    int mismatched = 0;

    // Model: requests waiting to be issued, and issued requests awaiting a response.
    logic [DATA_W-1:0] m_pend[$];
    logic [DATA_W-1:0] m_iss[$];
    logic              m_err;
    logic [31:0]       m_preq, m_pstall;

    dc_req_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .fifo_data_o(fifo_data_o), .fifo_valid_o(fifo_valid_o), .pop_i(pop_i),
        .count_o(count_o), .err_o(err_o),
        .perf_req_o(perf_req_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_iss.delete();
        m_err   = 1'b0;
        m_preq  = '0;
        m_pstall = '0;
    endtask

    task automatic check_all();
        int occ;
        logic [IDX_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_head;
        occ      = m_pend.size() + m_iss.size();
        exp_addr = '0;
        exp_head = '0;
        if (m_pend.size() != 0) exp_addr = m_pend[0][15:8];
        if (m_iss.size() != 0)  exp_head = m_iss[0];
        chk("count", DATA_W'(count_o), DATA_W'(occ));
        chk("req_ready", DATA_W'(req_ready_o), DATA_W'(occ != DEPTH));
        chk("arvalid", DATA_W'(arvalid_o), DATA_W'(m_pend.size() != 0));
        chk("araddr", DATA_W'(araddr_o), DATA_W'(exp_addr));
        chk("fifo_valid", DATA_W'(fifo_valid_o), DATA_W'(m_iss.size() != 0));
        chk("fifo_data", fifo_data_o, exp_head);
        chk("err", DATA_W'(err_o), DATA_W'(m_err));
`ifdef DC_REQ_Q_PERF_EN
        chk("perf_req", DATA_W'(perf_req_o), DATA_W'(m_preq));
        chk("perf_stall", DATA_W'(perf_stall_o), DATA_W'(m_pstall));
`else
        chk("perf_req", DATA_W'(perf_req_o), '0);
        chk("perf_stall", DATA_W'(perf_stall_o), '0);
`endif
    endtask

    // One clock: drive inputs, decide the model's moves from pre-edge state, then compare.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ar, input logic p);
        bit ready, do_push, do_iss, do_pop;
        logic [DATA_W-1:0] x;
        req_valid_i = v;
        req_data_i  = d;
        arready_i   = ar;
        pop_i       = p;
        ready   = (m_pend.size() + m_iss.size()) != DEPTH;
        do_push = v && ready;
        do_iss  = ar && (m_pend.size() != 0);
        do_pop  = p && (m_iss.size() != 0);
        @(posedge clk);
        if (p && !do_pop) m_err = 1'b1;
        if (v && !ready)  m_pstall = m_pstall + 32'd1;
        if (do_pop) x = m_iss.pop_front();
        if (do_iss) begin
            x = m_pend.pop_front();
            m_iss.push_back(x);
        end
        if (do_push) begin
            m_pend.push_back(d);
            m_preq = m_preq + 32'd1;
        end
        #1;
        check_all();
    endtask

    function automatic logic [DATA_W-1:0] mkreq(input logic wr, input logic [63:0] wd, input logic [15:0] a);
        return {wr, wd, a};
    endfunction

    initial begin
        logic [IDX_W-1:0] held_addr;
        logic [DATA_W-1:0] rnd;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cycle(0, '0, 0, 0);

        // Single read request through issue and pop
        cycle(1, mkreq(0, 64'h0, 16'h0A0A), 1, 0);
        chk("first_araddr", DATA_W'(araddr_o), DATA_W'(8'h0A));
        cycle(0, '0, 1, 0);
        chk("first_head", DATA_W'(fifo_data_o[15:0]), DATA_W'(16'h0A0A));
        cycle(0, '0, 1, 1);
        chk("first_empty", DATA_W'(count_o), '0);

        // Fill with DRAM stalled, then hold a ninth request
        for (int i = 0; i < 8; i++) cycle(1, mkreq(0, 64'(i * 3), {8'(i + 16), 8'h5A}), 0, 0);
        chk("full_ready", DATA_W'(req_ready_o), '0);
        chk("full_count", DATA_W'(count_o), DATA_W'(8));
        held_addr = araddr_o;
        for (int i = 0; i < 3; i++) cycle(1, mkreq(0, 64'hDEAD, 16'hFFFF), 0, 0);
        chk("held_araddr", DATA_W'(araddr_o), DATA_W'(held_addr));
        chk("held_fifo_valid", DATA_W'(fifo_valid_o), '0);

        // Release DRAM and drain with one pop per cycle
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 1);

        // Second burst across the pointer wrap, streaming issue and pop
        for (int i = 0; i < 8; i++) cycle(1, mkreq(0, 64'(i), {8'(i), 8'h00}), 1, m_iss.size() != 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, m_iss.size() != 0);

        // Push, issue and pop together at occupancy 3
        for (int i = 0; i < 3; i++) cycle(1, mkreq(0, 64'(100 + i), 16'(16'h1100 + i)), 0, 0);
        cycle(0, '0, 1, 0);
        cycle(1, mkreq(0, 64'd200, 16'h2200), 1, 1);
        chk("concurrent_count", DATA_W'(count_o), DATA_W'(3));
        for (int i = 0; i < 6; i++) cycle(0, '0, 1, m_iss.size() != 0);

        // Pop with nothing issued sets the sticky error
        cycle(0, '0, 0, 1);
        chk("err_set", DATA_W'(err_o), DATA_W'(1));
        cycle(0, '0, 0, 0);
        cycle(1, mkreq(0, 64'd7, 16'h3300), 0, 0);

        // Asynchronous reset in the middle of a five-request burst
        for (int i = 0; i < 3; i++) cycle(1, mkreq(0, 64'(i), 16'(16'h4400 + i)), 1, 0);
        req_valid_i = 1'b0;
        arready_i   = 1'b0;
        pop_i       = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_err", DATA_W'(err_o), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // Write request payload is delivered intact
        cycle(1, mkreq(1, 64'd100, 16'h000A), 1, 0);
        cycle(0, '0, 1, 0);
        chk("wr_flag", DATA_W'(fifo_data_o[80]), DATA_W'(1));
        chk("wr_data", DATA_W'(fifo_data_o[79:16]), DATA_W'(64'd100));
        cycle(0, '0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            cycle(($urandom % 4) != 0, rnd, ($urandom % 3) != 0,
                  (($urandom % 3) != 0) && (m_iss.size() != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
